// File: rtl/fp_mult_seq_if.sv
// Start/done handshake bundle between the power controller and the sequential fp multiplier.
interface fp_mult_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        busy;
  logic        done;

  modport master (output start, A, B, input result, overflow, underflow, busy, done);
  modport slave  (input start, A, B, output result, overflow, underflow, busy, done);
endinterface

// File: rtl/fp_mult_seq.sv
// Sequential binary32 multiplier: one shift-add partial-product step per clock,
// then a single normalise/round/pack cycle. Latency is fixed for every operand class.
module fp_mult_seq #(
  parameter int MANT_W   = 24,
  parameter int EXP_BIAS = 127
) (
  input  logic          CLK2,
  input  logic          RST,
  fp_mult_seq_if.slave  bus
);

  localparam int ACC_W = 2*MANT_W;

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;
  typedef enum logic [2:0] {CL_NUM, CL_NAN, CL_INFZ, CL_INF, CL_ZERO} class_t;

  state_t              r_state, w_state_nxt;
  class_t              r_class, w_class;
  logic                r_sign;
  logic signed [9:0]   r_expsum;
  logic [ACC_W-1:0]    r_acc, r_mcand;
  logic [MANT_W-1:0]   r_mplier;
  logic [4:0]          r_count;
  logic [31:0]         r_result;
  logic                r_ovf, r_unf, r_busy, r_done;

  // Operand classification, decoded straight off the bus at the start edge.
  logic [7:0]  w_a_exp, w_b_exp;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_a_exp  = bus.A[30:23];
  assign w_b_exp  = bus.B[30:23];
  assign w_a_nan  = (&w_a_exp) &&  (|bus.A[22:0]);
  assign w_b_nan  = (&w_b_exp) &&  (|bus.B[22:0]);
  assign w_a_inf  = (&w_a_exp) && !(|bus.A[22:0]);
  assign w_b_inf  = (&w_b_exp) && !(|bus.B[22:0]);
  assign w_a_zero = (w_a_exp == 8'd0);
  assign w_b_zero = (w_b_exp == 8'd0);

  always_comb begin
    w_class = CL_NUM;
    if (w_a_nan || w_b_nan)                            w_class = CL_NAN;
    else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) w_class = CL_INFZ;
    else if (w_a_inf || w_b_inf)                       w_class = CL_INF;
    else if (w_a_zero || w_b_zero)                     w_class = CL_ZERO;
  end

  // Normalise and round-to-nearest-even from the finished accumulator.
  logic              w_hi, w_guard, w_sticky, w_inc;
  logic [22:0]       w_mant;
  logic [23:0]       w_mant_r;
  logic signed [9:0] w_exp;
  logic [31:0]       w_result;
  logic              w_ovf, w_unf;

  always_comb begin
    w_hi     = r_acc[ACC_W-1];
    w_mant   = w_hi ? r_acc[46:24] : r_acc[45:23];
    w_guard  = w_hi ? r_acc[23]    : r_acc[22];
    w_sticky = w_hi ? (|r_acc[22:0]) : (|r_acc[21:0]);
    w_inc    = w_guard & (w_sticky | w_mant[0]);
    w_mant_r = {1'b0, w_mant} + {23'd0, w_inc};
    w_exp    = r_expsum + 10'(w_hi) + 10'(w_mant_r[23]);
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    w_result = {r_sign, w_exp[7:0], w_mant_r[22:0]};
    if (w_exp >= 10'sd255) begin
      w_result = {r_sign, 8'hFF, 23'h0};
      w_ovf    = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      w_result = {r_sign, 31'h0};
      w_unf    = 1'b1;
    end
    case (r_class)
      CL_NAN, CL_INFZ: begin w_result = 32'h7FC00000;              w_ovf = 1'b0; w_unf = 1'b0; end
      CL_INF:          begin w_result = {r_sign, 8'hFF, 23'h0};    w_ovf = 1'b0; w_unf = 1'b0; end
      CL_ZERO:         begin w_result = {r_sign, 31'h0};           w_ovf = 1'b0; w_unf = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK2 or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = MUL;
      MUL:  if (r_count == 5'd1) w_state_nxt = NORM;
      NORM: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK2 or negedge RST) begin
    if (!RST) begin
      r_class  <= CL_NUM;
      r_sign   <= 1'b0;
      r_expsum <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_sign   <= bus.A[31] ^ bus.B[31];
          r_expsum <= 10'(w_a_exp) + 10'(w_b_exp) - 10'(EXP_BIAS);
          r_mcand  <= {{(ACC_W-MANT_W){1'b0}}, 1'b1, bus.A[22:0]};
          r_mplier <= {1'b1, bus.B[22:0]};
          r_acc    <= '0;
          r_count  <= 5'(MANT_W);
          r_class  <= w_class;
          r_busy   <= 1'b1;
        end
        MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count - 5'd1;
        end
        NORM: begin
          r_result <= w_result;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed bench for fp_mult_seq: hand-computed products, latency, specials and handshake corners.
module tb_fp_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fp_mult_seq_if bus();

  fp_mult_seq #(.MANT_W(24), .EXP_BIAS(127)) dut (.CLK2(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; leaves us at the negedge right after the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n  = -1;
    nb = bus.busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin n = i; break; end
      if (bus.busy === 1'b1) nb++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic eo, input logic eu);
    int n, nb;
    start_op(a, b);
    wait_done(n, nb);
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
    chk({tag, "_unf"}, {31'd0, bus.underflow}, {31'd0, eu});
    chk({tag, "_lat"}, 32'(n), 32'd25);
    @(negedge clk);
  endtask

  initial begin
    int n, nb, seen;
    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_res",  bus.result, 32'h0);
    chk("rst_ovf",  {31'd0, bus.overflow},  32'd0);
    chk("rst_unf",  {31'd0, bus.underflow}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy},      32'd0);
    chk("rst_done", {31'd0, bus.done},      32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 2.0 x 3.0 with latency and busy width
    start_op(32'h40000000, 32'h40400000);
    chk("busy_rise", {31'd0, bus.busy}, 32'd1);
    wait_done(n, nb);
    chk("m23_res",  bus.result, 32'h40C00000);
    chk("m23_lat",  32'(n),  32'd25);
    chk("m23_busyw", 32'(nb), 32'd25);
    chk("m23_busy_off", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.done}, 32'd0);
    chk("res_held",   bus.result, 32'h40C00000);

    run("m15",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
    run("rne",   32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0);
    run("ovf",   32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
    run("unf",   32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
    run("infz",  32'hFF800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0);
    run("infx",  32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0);
    run("nan",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
    run("neg",   32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);

    // start while busy must be ignored
    start_op(32'h40000000, 32'h40400000);
    repeat (5) @(negedge clk);
    start_op(32'h3FC00000, 32'h3FC00000);
    wait_done(n, nb);
    chk("ign_res", bus.result, 32'h40C00000);
    chk("ign_lat", 32'(n), 32'd19);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk("ign_nodone", 32'(seen), 32'd0);
    chk("ign_held",   bus.result, 32'h40C00000);

    // back-to-back: second start lands in the done cycle
    start_op(32'h3FC00000, 32'h3FC00000);
    wait_done(n, nb);
    chk("b2b1_res", bus.result, 32'h40100000);
    start_op(32'h40000000, 32'h40400000);
    wait_done(n, nb);
    chk("b2b2_res", bus.result, 32'h40C00000);
    chk("b2b2_lat", 32'(n), 32'd25);
    @(negedge clk);

    // reset mid-operation aborts with no done
    start_op(32'h7F000000, 32'h7F000000);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_res",  bus.result, 32'h0);
    chk("mrst_ovf",  {31'd0, bus.overflow},  32'd0);
    chk("mrst_unf",  {31'd0, bus.underflow}, 32'd0);
    chk("mrst_busy", {31'd0, bus.busy},      32'd0);
    chk("mrst_done", {31'd0, bus.done},      32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("mrst_quiet", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
